// File: rtl/frame_parity_unit.sv
// rtl/frame_parity_unit.sv - multi-word frame parity generator/checker with saturating error count
//
// Purpose: reduces each frame of FRAME_LEN WIDTH-bit words to one parity bit
// (even or odd, chosen by the first word of the frame). It can also compare a
// received parity bit against the generated one and count mismatching frames.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   in_data is valid
//   in_ready   block can accept a word this cycle
//   in_data    data word (WIDTH bits)
//   odd_mode   0 = even, 1 = odd parity; sampled with the first word of a frame
//   chk_en     enable the check; sampled with the last word of a frame
//   chk_bit    received parity bit; sampled with the last word of a frame
//   out_valid  frame result is valid
//   out_ready  consumer accepts the result
//   out_parity generated parity bit for the frame
//   out_err    check mismatch for the frame
//   err_count  saturating count of erroneous frames (CNT_W bits)
module frame_parity_unit #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             odd_mode,
  input  logic             chk_en,
  input  logic             chk_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic [CW-1:0]    word_cnt_q, word_cnt_d;
  logic             odd_q, odd_d;
  logic             chk_en_q, chk_en_d;
  logic             chk_bit_q, chk_bit_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_parity_q, out_parity_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic accept;
  logic word_par;
  logic is_last;

  assign accept   = in_valid & in_ready_q;
  assign word_par = ^in_data;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    word_cnt_d   = word_cnt_q;
    odd_d        = odd_q;
    chk_en_d     = chk_en_q;
    chk_bit_d    = chk_bit_q;
    out_valid_d  = out_valid_q;
    out_parity_d = out_parity_q;
    err_count_d  = err_count_q;
    is_last      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          // First word replaces the accumulator rather than folding into it.
          acc_d = word_par;
          odd_d = odd_mode;
          if (FRAME_LEN == 1) begin
            word_cnt_d = '0;
            is_last    = 1'b1;
          end else begin
            word_cnt_d = CW'(1);
            state_d    = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = acc_q ^ word_par;
          if (word_cnt_q == LAST_IDX) begin
            word_cnt_d = '0;
            is_last    = 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          if (out_err && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Closing a frame: capture the check inputs and the final parity together.
    if (is_last) begin
      state_d      = DONE;
      out_valid_d  = 1'b1;
      chk_en_d     = chk_en;
      chk_bit_d    = chk_bit;
      out_parity_d = acc_d ^ odd_d;
    end

    // Registered so that in_ready stays low through reset and rises on the
    // first edge afterwards.
    in_ready_d = (state_d != DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= 1'b0;
      word_cnt_q   <= '0;
      odd_q        <= 1'b0;
      chk_en_q     <= 1'b0;
      chk_bit_q    <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_parity_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      word_cnt_q   <= word_cnt_d;
      odd_q        <= odd_d;
      chk_en_q     <= chk_en_d;
      chk_bit_q    <= chk_bit_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_parity_q <= out_parity_d;
      err_count_q  <= err_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_parity = out_parity_q;
  // Derived only from registered latches, so it is stable while out_valid is held.
  assign out_err    = chk_en_q & (chk_bit_q ^ out_parity_q);
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_frame_parity_unit.sv
// tb/tb_frame_parity_unit.sv - self-checking bench for frame_parity_unit
module tb_frame_parity_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       odd_mode;
  logic       chk_en;
  logic       chk_bit;
  logic       out_ready;

  logic       in_ready, out_valid, out_parity, out_err;
  logic [7:0] err_count;
  logic       s_in_ready, s_out_valid, s_out_parity, s_out_err;
  logic [1:0] s_err_count;

  int passed = 0;
  int total  = 0;
  int exp_cnt8;
  int exp_cnt2;

  always #5 clk = ~clk;

  frame_parity_unit #(.WIDTH(8), .FRAME_LEN(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .odd_mode(odd_mode), .chk_en(chk_en), .chk_bit(chk_bit), .out_valid(out_valid),
    .out_ready(out_ready), .out_parity(out_parity), .out_err(out_err), .err_count(err_count)
  );

  frame_parity_unit #(.WIDTH(8), .FRAME_LEN(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .odd_mode(odd_mode), .chk_en(chk_en), .chk_bit(chk_bit), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_parity(s_out_parity), .out_err(s_out_err), .err_count(s_err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: count every 1 bit in the frame; parity makes the total even
  // (mode 0) or odd (mode 1).
  function automatic logic model_parity(input logic [7:0] w [4], input logic odd);
    int ones = 0;
    for (int i = 0; i < 4; i++) ones += $countones(w[i]);
    return ((ones % 2) == 1) ^ odd;
  endfunction

  // Drive one frame, then check the result and the handshake.
  // Non-last words carry inverted chk values and later words a separate
  // odd_mode, which the DUT must ignore.
  task automatic run_frame(input logic [7:0] w [4], input logic odd0, input logic odd_later,
                           input logic ce, input logic cb, input int gap, input int stall);
    logic ep, ee;
    int   guard;
    ep = model_parity(w, odd0);
    ee = ce & (cb != ep);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        repeat (gap) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data  = 8'hA5;
          @(posedge clk);
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w[i];
      odd_mode = (i == 0) ? odd0 : odd_later;
      chk_en   = (i == 3) ? ce : ~ce;
      chk_bit  = (i == 3) ? cb : ~cb;
      guard = 0;
      while (!in_ready && guard < 20) begin
        @(posedge clk);
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) chk("accept_timeout", 32'd1, 32'd0);
      chk("no_early_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("out_valid_latency", {31'd0, out_valid}, 32'd1);
    chk("out_parity", {31'd0, out_parity}, {31'd0, ep});
    chk("out_err", {31'd0, out_err}, {31'd0, ee});
    chk("in_ready_done", {31'd0, in_ready}, 32'd0);
    out_ready = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_parity", {31'd0, out_parity}, {31'd0, ep});
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    if (ee) begin
      if (exp_cnt8 < 255) exp_cnt8++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
    @(negedge clk);
    chk("valid_cleared", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("err_count", {24'd0, err_count}, exp_cnt8);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_cnt8 = 0;
    exp_cnt2 = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] w [4];
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    odd_mode  = 1'b0;
    chk_en    = 1'b0;
    chk_bit   = 1'b0;
    out_ready = 1'b1;
    exp_cnt8  = 0;
    exp_cnt2  = 0;

    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Even frame, 11 ones -> parity 1.
    w = '{8'h01, 8'h03, 8'h00, 8'hFF};
    run_frame(w, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("even_dir_par", {31'd0, model_parity(w, 1'b0)}, 32'd1);
    // Odd mode latched on word 0, toggled afterwards -> parity 0.
    run_frame(w, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    // Check path: 16 ones, chk_bit=1 -> error; then chk_bit=0 -> no error.
    w = '{8'h0F, 8'h0F, 8'h0F, 8'h0F};
    run_frame(w, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
    chk("err_count_one", {24'd0, err_count}, 32'd1);
    run_frame(w, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    chk("err_count_hold", {24'd0, err_count}, 32'd1);
    // Back-pressure: 3-cycle gap mid-frame, 5-cycle output stall.
    w = '{8'h01, 8'h03, 8'h00, 8'hFF};
    run_frame(w, 1'b0, 1'b0, 1'b0, 1'b0, 3, 5);

    // Saturation on the 2-bit counter: 1,2,3,3,3.
    do_reset();
    w = '{8'h0F, 8'h0F, 8'h0F, 8'h0F};
    for (int k = 1; k <= 5; k++) begin
      run_frame(w, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
      chk($sformatf("sat_%0d", k), {30'd0, s_err_count}, (k < 3) ? k : 3);
    end

    // Asynchronous reset after two accepted words.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h07;
    @(posedge clk);
    @(negedge clk);
    in_data = 8'h01;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("amid_in_ready", {31'd0, in_ready}, 32'd0);
    chk("amid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("amid_out_parity", {31'd0, out_parity}, 32'd0);
    chk("amid_out_err", {31'd0, out_err}, 32'd0);
    chk("amid_err_count", {24'd0, err_count}, 32'd0);
    chk("amid_sat_count", {30'd0, s_err_count}, 32'd0);
    exp_cnt8 = 0;
    exp_cnt2 = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    w = '{8'h80, 8'h00, 8'h00, 8'h00};
    run_frame(w, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

    // Randomised frames against the model.
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
      run_frame(w, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3));
      chk("rand_sat_count", {30'd0, s_err_count}, exp_cnt2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_parity_unit.md
Name: frame_parity_unit

Overview:
- Parametrised, multi-word successor to the fixed 3-input XNOR parity cell.
- Accepts a stream of WIDTH-bit words over a valid/ready handshake and reduces each frame of FRAME_LEN words to one parity bit.
- Even or odd parity is selectable per frame.
- Optionally checks a received parity bit, flags mismatches and keeps a saturating error count. Sits between a word source and a result consumer in the lab datapath.

Parameters:
- WIDTH, 8, bits per input word (>=1).
- FRAME_LEN, 4, words per frame (>=1).
- CNT_W, 8, width of err_count (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  data word.
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled with the first word of a frame.
- chk_en  input  1  enable the check; sampled with the last word of a frame.
- chk_bit  input  1  received parity bit; sampled with the last word of a frame.
- out_valid  output  1  frame result is valid.
- out_ready  input  1  consumer accepts the result.
- out_parity  output  1  generated parity bit for the frame.
- out_err  output  1  check mismatch for the frame.
- err_count  output  CNT_W  saturating count of erroneous frames.

Behaviour:
- Reset: clk is the only clock. While rst=1, asynchronously force:
  - state=IDLE, acc=0, word_cnt=0
  - in_ready=0 during reset; 1 from the first clk edge after rst falls
  - out_valid=0, out_parity=0, out_err=0, err_count=0
  - mode/check latches = 0
- Input acceptance: a word is accepted on a rising edge with in_valid=1 and in_ready=1. in_ready=1 in IDLE and ACCUM, 0 in DONE.
- Datapath:
  - Per accepted word, acc_next = acc XOR (XOR-reduce in_data). On the first word of a frame acc is replaced, not XORed.
  - word_cnt counts 0..FRAME_LEN-1 and wraps to 0 after the last word.
  - Width of word_cnt = max(1, clog2(FRAME_LEN)).
- State machine:
  - IDLE: accept word -> latch odd_mode, acc = XOR-reduce(in_data), word_cnt=1. Go to ACCUM, or go directly to DONE if FRAME_LEN=1.
  - ACCUM: accept word -> update acc and word_cnt. If this is word FRAME_LEN-1, go to DONE. No accept -> hold.
  - DONE:
    - out_valid=1.
    - out_parity = final_acc when latched odd_mode=0; NOT final_acc when latched odd_mode=1.
    - Result: total ones in frame plus out_parity is even (mode 0) or odd (mode 1).
    - out_err = latched chk_en AND (latched chk_bit != out_parity).
    - On out_valid AND out_ready -> IDLE, out_valid=0 next cycle.
    - If out_err=1 on that handshake, err_count increments unless it is at 2^CNT_W-1, where it holds.
- Latency: out_valid rises on the first edge after the last word is accepted, i.e. one cycle after the final handshake. Outputs are registered and stable while out_valid=1 and out_ready=0.
- Back-pressure:
  - Holding out_ready=0 stalls input (in_ready=0). No word is dropped or double-counted.
  - in_valid gaps mid-frame leave acc and word_cnt unchanged.
- Mid-frame inputs: odd_mode changes after the first word, and chk_en/chk_bit values on non-last words, are ignored.
- Simultaneous events: the out handshake and a new input in the same cycle cannot occur, since in_ready=0 in DONE. The next frame starts one cycle after the out handshake at the earliest. Sustained throughput is FRAME_LEN+1 cycles per frame.
- Reset mid-frame or while in DONE: the partial frame is discarded, err_count clears, and the block returns to IDLE.

Test Plan:
- Even frame: WIDTH=8, FRAME_LEN=4, odd_mode=0, words 0x01,0x03,0x00,0xFF (11 ones), in_valid continuous -> out_valid one cycle after 4th accept, out_parity=1, out_err=0.
- Odd mode, same words, odd_mode=1 on word 0 and toggled to 0 on word 2 -> out_parity=0 (mode latched at first word).
- Check path: words 0x0F x4 (16 ones), even mode, chk_en=1, chk_bit=1 on last word -> out_parity=0, out_err=1, err_count 0->1 on out handshake; repeat with chk_bit=0 -> out_err=0, err_count stays 1.
- Back-pressure and gaps: in_valid low 3 cycles between words 1 and 2; out_ready low 5 cycles in DONE -> in_ready=0 throughout the stall, outputs stable, next frame's first word accepted exactly one cycle after out handshake.
- Saturation: CNT_W=2, 5 consecutive erroneous frames -> err_count 1,2,3,3,3.
- Reset mid-operation: assert rst asynchronously after 2 words -> all outputs 0 immediately; subsequent full frame 0x80,0x00,0x00,0x00 in even mode -> out_parity=1.
